// File: rtl/ldpc_bitflip_decoder.sv
// Hard-decision bit-flipping LDPC decoder.
// A received word is captured, its syndrome is checked, and on each FLIP
// iteration every bit touching the largest number of unsatisfied checks is
// inverted, until the syndrome clears or the iteration budget runs out.
module ldpc_bitflip_decoder #(
    parameter int N = 15,
    parameter int M = 15,
    // Row i occupies bits [i*N +: N]; default rows have ones at (i+{0,1,3,7}) mod 15.
    parameter logic [N*M-1:0] H = {
        15'h4045, 15'h6022, 15'h3011, 15'h5808, 15'h2C04,
        15'h1602, 15'h0B01, 15'h4580, 15'h22C0, 15'h1160,
        15'h08B0, 15'h0458, 15'h022C, 15'h0116, 15'h008B
    },
    parameter int MAX_ITER = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c_out,
    output logic [M-1:0] s,
    output logic         error,
    output logic         fail,
    output logic [7:0]   iter
);

    localparam int CW = $clog2(M + 1);
    localparam logic [7:0] MAX_IT = 8'(MAX_ITER);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        FLIP,
        DONE
    } state_t;

    state_t          state;
    logic [N-1:0]    work;
    logic [7:0]      iter_cnt;
    logic [M-1:0]    syn;
    logic [CW-1:0]   cnt [N];
    logic [CW-1:0]   max_cnt;
    logic [N-1:0]    flip_mask;

    // Syndrome of the working word over GF(2).
    always_comb begin
        syn = '0;
        for (int unsigned i = 0; i < M; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                syn[i] = syn[i] ^ (H[i*N+j] & work[j]);
            end
        end
    end

    // Per-bit unsatisfied-check counts, their maximum and the resulting flip set.
    always_comb begin
        max_cnt   = '0;
        flip_mask = '0;
        for (int unsigned j = 0; j < N; j++) begin
            cnt[j] = '0;
            for (int unsigned i = 0; i < M; i++) begin
                cnt[j] = cnt[j] + CW'(H[i*N+j] & syn[i]);
            end
            if (cnt[j] > max_cnt) max_cnt = cnt[j];
        end
        for (int unsigned j = 0; j < N; j++) begin
            flip_mask[j] = (max_cnt != '0) && (cnt[j] == max_cnt);
        end
    end

    // Control FSM with registered handshake and result outputs.
    // Results are loaded on the CHECK->DONE edge; out_valid follows one cycle
    // later, giving the two-cycle clean-word latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            work      <= '0;
            iter_cnt  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            c_out     <= '0;
            s         <= '0;
            error     <= 1'b0;
            fail      <= 1'b0;
            iter      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= c_in;
                        iter_cnt <= '0;
                        in_ready <= 1'b0;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    s <= syn;
                    if (iter_cnt == '0) error <= |syn;
                    if ((syn == '0) || (iter_cnt == MAX_IT)) begin
                        c_out <= work;
                        fail  <= |syn;
                        iter  <= iter_cnt;
                        state <= DONE;
                    end else begin
                        state <= FLIP;
                    end
                end
                FLIP: begin
                    work     <= work ^ flip_mask;
                    iter_cnt <= iter_cnt + 8'd1;
                    state    <= CHECK;
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ldpc_bitflip_decoder.md
LDPC_BITFLIP_DECODER -- requirements
Module: ldpc_bitflip_decoder

Interface
REQ-001 Parameter N, default 15: codeword length in bits.
REQ-002 Parameter M, default 15: number of parity checks (syndrome width).
REQ-003 Parameter H, default cyclic (15,15) matrix: flat N*M-bit parity-check matrix, bit H[i*N+j] = check i covers codeword bit j. Default row i has ones at columns (i+{0,1,3,7}) mod 15.
REQ-004 Parameter MAX_ITER, default 8: maximum flip iterations, legal range 0..255.
REQ-005 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 in_valid  in  1  received word present on c_in.
REQ-009 in_ready  out  1  block can accept a word.
REQ-010 c_in  in  N  received (channel) codeword.
REQ-011 out_valid  out  1  decode result valid.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 c_out  out  N  decoded codeword.
REQ-014 s  out  M  syndrome of c_out.
REQ-015 error  out  1  syndrome of the received word was nonzero.
REQ-016 fail  out  1  syndrome still nonzero after MAX_ITER iterations.
REQ-017 iter  out  8  number of flip iterations performed.

Function
REQ-018 FSM states IDLE, CHECK, FLIP, DONE, with IDLE after reset.
REQ-019 IDLE: in_ready=1, all other handshake outputs 0.
- On in_valid: c_in captured into the working register, iter cleared, go to CHECK.
REQ-020 CHECK: syndrome = H times working word over GF(2), registered into s; route by syndrome and iter:
- First CHECK after capture: error <= (syndrome != 0).
- Syndrome == 0 -> DONE with fail=0.
- Else if iter == MAX_ITER -> DONE with fail=1.
- Else -> FLIP.
REQ-021 FLIP, bit selection: for each bit j, cnt[j] = number of unsatisfied checks i with H[i*N+j]=1. Every bit whose cnt[j] equals max(cnt) (max>0) is inverted in one cycle.
REQ-022 FLIP, exit: iter increments by 1, then go to CHECK.
REQ-023 cnt width SHALL hold M without overflow; iter saturates logically at MAX_ITER (never wraps).
REQ-024 DONE: out_valid=1; c_out, s, error, fail, iter held stable until out_valid && out_ready, then IDLE.
REQ-025 in_ready SHALL be 0 in CHECK, FLIP and DONE; no input is accepted until the prior result is consumed.
REQ-026 Latency: out_valid rises 2 cycles after the accepting edge for a clean word, plus 2 cycles per flip iteration.
REQ-027 c_out, s, error, fail and iter SHALL be registered outputs; they are undefined-free (hold last values) outside DONE.
REQ-028 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-029 rst asserted at any time, including mid-decode, SHALL immediately force IDLE and clear the working register.
REQ-030 rst SHALL clear c_out=0, s=0, error=0, fail=0, iter=0, out_valid=0 and in_ready=1.
REQ-031 The first accept SHALL be possible on the first rising clk edge after rst deasserts.

Verification
REQ-032 Clean word: c_in=15'h0000 -> out_valid 2 cycles after accept, with c_out=0, s=0, error=0, fail=0, iter=0.
REQ-033 Single error: c_in=15'h0001 -> c_out=0, s=0, error=1, fail=0, iter=1, out_valid 4 cycles after accept.
REQ-034 Double error: c_in=15'h0003 -> both bits flipped in one FLIP, giving c_out=0, error=1, fail=0, iter=1.
REQ-035 MAX_ITER=0 with c_in=15'h0001 -> c_out=15'h0001, error=1, fail=1, iter=0, s nonzero.
REQ-036 Backpressure: out_ready held low 5 cycles in DONE -> outputs stable and in_ready=0 throughout; the next word is accepted only after the out_ready handshake.
REQ-037 Reset mid-decode: rst pulsed during FLIP -> next cycle IDLE, out_valid=0, in_ready=1, iter=0; a subsequent clean word decodes normally.
